// File: rtl/stream_arb_mux_if.sv
// Handshake/bus bundle for stream_arb_mux.
// Signal names are given from the arbiter's point of view.
// The environment drives the i_* signals through "master".
// The arbiter drives the o_* signals through "slave".
interface stream_arb_mux_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 5
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

  logic [1:0]                       i_mode;
  logic [SEL_WIDTH-1:0]             i_sel;
  logic [NUM_INPUTS-1:0]            i_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data;
  logic [NUM_INPUTS-1:0]            o_ready;
  logic                             o_valid;
  logic [DATA_WIDTH-1:0]            o_data;
  logic [SEL_WIDTH-1:0]             o_sel;
  logic                             i_ready;

  modport master (
    output i_mode, i_sel, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sel
  );

  modport slave (
    input  i_mode, i_sel, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sel
  );
endinterface

// File: rtl/stream_arb_mux.sv
// N-to-1 valid/ready stream multiplexer.
// Arbitration is selectable per cycle: round-robin, fixed priority or forced select.
// A single registered output stage sustains one beat per cycle.
module stream_arb_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 5
) (
  input  logic            i_clk,
  input  logic            i_arst,
  stream_arb_mux_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);
  // Every value of i_sel maps to a bit here; bits at or above NUM_INPUTS read as 0.
  localparam int SEL_SPAN  = 1 << SEL_WIDTH;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [SEL_WIDTH-1:0]  r_ptr;

  logic                  w_load_en;
  logic                  w_gnt_valid;
  logic [SEL_WIDTH-1:0]  w_gnt_idx;
  logic                  w_xfer;
  logic [SEL_SPAN-1:0]   w_valid_pad;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [NUM_INPUTS-1:0] w_ready;
  logic [SEL_WIDTH-1:0]  w_ptr_next;

  // The stage can take a beat whenever it is empty or draining this cycle.
  assign w_load_en   = !r_valid || bus.i_ready;
  assign w_valid_pad = SEL_SPAN'(bus.i_valid);

  // Select the granted channel for the current mode.
  always_comb begin : p_grant
    int v_idx;
    v_idx       = 0;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    case (bus.i_mode)
      2'd0: begin
        // Scan downward so the offset closest to the pointer is written last and wins.
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          v_idx = int'(r_ptr) + k;
          if (v_idx >= NUM_INPUTS) v_idx = v_idx - NUM_INPUTS;
          if (bus.i_valid[v_idx]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = SEL_WIDTH'(v_idx);
          end
        end
      end
      2'd1: begin
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          if (bus.i_valid[k]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = SEL_WIDTH'(k);
          end
        end
      end
      2'd2: begin
        if (w_valid_pad[bus.i_sel]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = bus.i_sel;
        end
      end
      default: begin
        w_gnt_valid = 1'b0;
      end
    endcase
  end

  // Route the granted channel's payload to the stage input.
  always_comb begin : p_data_mux
    w_gnt_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (w_gnt_idx == SEL_WIDTH'(k)) w_gnt_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // One-hot ready to the granted channel, held at zero while in reset.
  always_comb begin : p_ready
    w_ready = '0;
    if (i_arst && w_load_en && w_gnt_valid) w_ready = NUM_INPUTS'(1) << w_gnt_idx;
  end

  assign w_xfer     = w_load_en && w_gnt_valid;
  assign w_ptr_next = (w_gnt_idx == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Output stage and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load_en) r_valid <= w_xfer;
      if (w_xfer) begin
        r_data <= w_gnt_data;
        r_sel  <= w_gnt_idx;
        if (bus.i_mode == 2'd0) r_ptr <= w_ptr_next;
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_sel   = r_sel;
endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux with 5 channels of 64-bit payload.
module tb_stream_arb_mux;
  localparam int DW = 64;
  localparam int N  = 5;

  logic clk;
  logic arst;
  int   n_checks;
  int   n_errors;

  stream_arb_mux_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus ();

  stream_arb_mux #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(N)
  ) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pay(input int k);
    return {32'hCAFE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mode, input logic [2:0] sel,
                       input logic [4:0] valid, input logic rdy);
    bus.i_mode  = mode;
    bus.i_sel   = sel;
    bus.i_valid = valid;
    bus.i_ready = rdy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                         input logic [2:0] s);
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(v));
    chk({tag, ".data"},  bus.o_data,       d);
    chk({tag, ".sel"},   64'(bus.o_sel),   64'(s));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    arst     = 1'b0;
    for (int k = 0; k < N; k++) bus.i_data[k*DW +: DW] = pay(k);
    drive(2'd0, 3'd0, 5'b11111, 1'b1);

    // Reset held with everything requesting.
    tick();
    tick();
    chk_out("reset", 1'b0, 64'h0, 3'd0);
    chk("reset.ready", 64'(bus.o_ready), 64'h0);

    // Release between edges; channel 0 is offered first.
    arst = 1'b1;
    #1;
    chk("release.ready", 64'(bus.o_ready), 64'b00001);

    // Round-robin over all channels, one beat per cycle.
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, pay(k % 5), 3'(k % 5));
      chk($sformatf("rr%0d.ready", k), 64'(bus.o_ready), 64'(5'b00001 << ((k + 1) % 5)));
    end

    // Only channel 3 requests: moves the pointer to 4.
    drive(2'd0, 3'd0, 5'b01000, 1'b1);
    chk("ptr4.ready", 64'(bus.o_ready), 64'b01000);
    tick();
    chk("ptr4.sel", 64'(bus.o_sel), 64'd3);

    // Sparse requests with wrap: 0, then 2, then 0.
    drive(2'd0, 3'd0, 5'b00101, 1'b1);
    chk("wrap0.ready", 64'(bus.o_ready), 64'b00001);
    tick();
    chk("wrap0.sel", 64'(bus.o_sel), 64'd0);
    chk("wrap1.ready", 64'(bus.o_ready), 64'b00100);
    tick();
    chk("wrap1.sel", 64'(bus.o_sel), 64'd2);
    chk("wrap2.ready", 64'(bus.o_ready), 64'b00001);
    tick();
    chk("wrap2.sel", 64'(bus.o_sel), 64'd0);
    // Pointer is now 1.

    // Fixed priority: lowest valid index.
    drive(2'd1, 3'd0, 5'b10110, 1'b1);
    chk("fixed.ready", 64'(bus.o_ready), 64'b00010);
    tick();
    chk_out("fixed", 1'b1, pay(1), 3'd1);

    // Forced select of a valid channel.
    drive(2'd2, 3'd3, 5'b01000, 1'b1);
    chk("force3.ready", 64'(bus.o_ready), 64'b01000);
    tick();
    chk_out("force3", 1'b1, pay(3), 3'd3);

    // Forced select of an invalid channel.
    drive(2'd2, 3'd3, 5'b00111, 1'b1);
    chk("force3inv.ready", 64'(bus.o_ready), 64'h0);

    // Forced select beyond the channel count; stage empties but keeps data/sel.
    drive(2'd2, 3'd6, 5'b11111, 1'b1);
    chk("force6.ready", 64'(bus.o_ready), 64'h0);
    tick();
    chk_out("force6", 1'b0, pay(3), 3'd3);

    // Reserved mode never grants.
    drive(2'd3, 3'd0, 5'b11111, 1'b1);
    chk("mode3.ready", 64'(bus.o_ready), 64'h0);
    tick();
    chk("mode3.valid", 64'(bus.o_valid), 64'd0);

    // Back to round-robin: pointer untouched by modes 1-3, still 1.
    drive(2'd0, 3'd0, 5'b11111, 1'b1);
    chk("rrback.ready", 64'(bus.o_ready), 64'b00010);
    tick();
    chk("rrback.sel", 64'(bus.o_sel), 64'd1);

    // Load 0xDEAD from channel 2 (pointer is 2).
    bus.i_data[2*DW +: DW] = 64'hDEAD;
    drive(2'd0, 3'd0, 5'b00100, 1'b1);
    chk("dead.ready", 64'(bus.o_ready), 64'b00100);
    tick();
    chk_out("dead", 1'b1, 64'hDEAD, 3'd2);

    // Backpressure for 3 cycles.
    bus.i_data[2*DW +: DW] = pay(2);
    drive(2'd0, 3'd0, 5'b11111, 1'b0);
    chk("stall.ready", 64'(bus.o_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("stall%0d", k), 1'b1, 64'hDEAD, 3'd2);
      chk($sformatf("stall%0d.ready", k), 64'(bus.o_ready), 64'h0);
    end

    // Ready rises: next beat (channel 3) loads in the same cycle.
    drive(2'd0, 3'd0, 5'b11111, 1'b1);
    chk("unstall.ready", 64'(bus.o_ready), 64'b01000);
    tick();
    chk_out("unstall", 1'b1, pay(3), 3'd3);

    // Reset mid-stream while stalled.
    drive(2'd0, 3'd0, 5'b11111, 1'b0);
    arst = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 64'h0, 3'd0);
    chk("midrst.ready", 64'(bus.o_ready), 64'h0);
    tick();

    // Release with nothing requesting: nothing emerges.
    arst = 1'b1;
    drive(2'd0, 3'd0, 5'b00000, 1'b1);
    chk("postrst.ready", 64'(bus.o_ready), 64'h0);
    tick();
    chk_out("postrst", 1'b0, 64'h0, 3'd0);

    // Pointer back at 0.
    drive(2'd0, 3'd0, 5'b11111, 1'b1);
    chk("postrst2.ready", 64'(bus.o_ready), 64'b00001);
    tick();
    chk_out("postrst2", 1'b1, pay(0), 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output.
- Arbitration is selectable per cycle: round-robin, fixed priority, or forced select.
- A single registered output stage gives full throughput.
- Sits in front of shared datapath resources, e.g. a common writeback or memory-request port fed by several units.

Parameters:
- DATA_WIDTH, 64, payload width per channel.
- NUM_INPUTS, 5, number of input channels (>= 2).
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the channel index. Derived; must not be overridden.

Ports:
- i_clk  input  1  clock, rising edge.
- i_arst  input  1  asynchronous reset, active-low.
- i_mode  input  2  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = forced select, 3 = reserved (no grant).
- i_sel  input  SEL_WIDTH  channel index used in mode 2.
- i_valid  input  NUM_INPUTS  per-channel valid.
- i_data  input  NUM_INPUTS*DATA_WIDTH  flattened payloads; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  output  NUM_INPUTS  per-channel ready, one-hot or zero.
- o_valid  output  1  output stage holds a beat.
- o_data  output  DATA_WIDTH  held payload.
- o_sel  output  SEL_WIDTH  source channel index of the held payload.
- i_ready  input  1  downstream ready.

Behaviour:
- Reset, while i_arst = 0:
  - o_valid = 0, o_data = 0, o_sel = 0.
  - Round-robin pointer = 0, so channel 0 has highest priority.
  - o_ready forced to all zeros.
- Load enable:
  - load_en = !o_valid | i_ready.
  - The stage accepts a new beat in the same cycle the old one drains, giving 1 beat/cycle sustained.
- Grant (combinational, each cycle, from i_valid, i_mode, i_sel and the pointer):
  - Mode 0: first valid channel scanning from the pointer upward, wrapping at NUM_INPUTS-1 to 0.
  - Mode 1: lowest-index valid channel.
  - Mode 2: channel i_sel if i_valid[i_sel] = 1. No grant if i_sel >= NUM_INPUTS or that channel is invalid.
  - Mode 3: no grant.
- Ready:
  - o_ready[g] = load_en & grant_valid for the granted channel g only.
  - All other bits are 0.
  - o_ready never depends on i_data.
- Transfer:
  - Occurs on channel g when i_valid[g] & o_ready[g].
  - On that edge: o_data <= channel g payload, o_sel <= g, o_valid <= 1.
  - If load_en and no transfer: o_valid <= 0. o_data and o_sel hold their last values.
- Latency: a beat accepted at edge t appears on o_valid/o_data immediately after edge t, i.e. one cycle of latency.
- Stall: while o_valid & !i_ready:
  - o_data and o_sel are stable.
  - All o_ready bits are 0.
  - No input is consumed.
- Pointer update:
  - Only on a transfer made while i_mode = 0: pointer <= (g == NUM_INPUTS-1) ? 0 : g+1.
  - Modes 1, 2 and 3 never modify the pointer.
- Mode or i_sel change mid-stream: takes effect in the same cycle for arbitration. A beat already held in the output stage is unaffected.
- Input protocol: an input may drop i_valid without a transfer. The block does not require input stability.
- Reset asserted mid-stream: the held beat is discarded immediately and the pointer returns to 0. No beat is emitted after reset release until a new transfer.
- Width rules:
  - Pointer wrap uses an explicit compare with NUM_INPUTS-1, so non-power-of-2 NUM_INPUTS is supported.
  - Indices >= NUM_INPUTS are never granted.

Test Plan:
- Reset: hold i_arst = 0 with all i_valid = 1 and i_ready = 1 -> o_valid = 0, o_data = 0, o_sel = 0, o_ready = 5'b00000. After release, the first transfer is from channel 0.
- Round-robin fairness: mode 0, i_valid = 5'b11111, i_ready = 1 for 10 cycles -> o_sel sequence 0,1,2,3,4,0,1,2,3,4, one beat per cycle, o_data equal to each channel's payload.
- Pointer wrap with sparse requests: mode 0, pointer at 4, i_valid = 5'b00101 -> grant channel 0, then channel 2, then channel 0.
- Fixed priority and forced select:
  - Mode 1, i_valid = 5'b10110 -> o_ready = 5'b00010.
  - Mode 2, i_sel = 3, i_valid = 5'b01000 -> o_ready = 5'b01000.
  - Mode 2, i_sel = 6 -> o_ready = 0.
  - Mode 3 -> o_ready = 0.
- Backpressure: held beat 0xDEAD from channel 2, i_ready = 0 for 3 cycles -> o_data = 0xDEAD, o_sel = 2 stable, o_ready = 0. When i_ready rises, the next beat loads in the same cycle with no bubble.
- Reset mid-stream: o_valid = 1, i_ready = 0, assert i_arst asynchronously between edges -> o_valid falls immediately. After release, the pointer is 0 and the previously held beat is never output.
